// File: rtl/cachepool_l1_coalescer.sv
// cachepool_l1_coalescer: merges consecutive same-line core word requests into one L1 line request
// carrying per-slot word index and ID so responses can be split downstream.
module cachepool_l1_coalescer #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int LineWidth     = 128,
    parameter int CoalFactor    = 2,
    parameter int IdWidth       = 6,
    parameter int TimeoutCycles = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [AddrWidth-1:0]              req_addr_i,
    input  logic                              req_write_i,
    input  logic [DataWidth-1:0]              req_data_i,
    input  logic [DataWidth/8-1:0]            req_strb_i,
    input  logic [IdWidth-1:0]                req_id_i,
    output logic                              line_valid_o,
    input  logic                              line_ready_i,
    output logic [AddrWidth-1:0]              line_addr_o,
    output logic                              line_write_o,
    output logic [LineWidth-1:0]              line_data_o,
    output logic [LineWidth/8-1:0]            line_strb_o,
    output logic [$clog2(CoalFactor+1)-1:0]   line_cnt_o,
    output logic [CoalFactor*$clog2(LineWidth/DataWidth)-1:0] line_word_o,
    output logic [CoalFactor*IdWidth-1:0]     line_id_o
);
    localparam int NumWords = LineWidth / DataWidth;
    localparam int WIdx     = $clog2(NumWords);
    localparam int LOff     = $clog2(LineWidth / 8);
    localparam int BW       = DataWidth / 8;
    localparam int CW       = $clog2(CoalFactor + 1);
    localparam int TW       = $clog2(TimeoutCycles + 1);
    localparam int TagW     = AddrWidth - LOff;

    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;

    state_t                        r_state;
    logic [TagW-1:0]               r_tag;
    logic                          r_write;
    logic [LineWidth-1:0]          r_data;
    logic [LineWidth/8-1:0]        r_strb;
    logic [CW-1:0]                 r_cnt;
    logic [CoalFactor*WIdx-1:0]    r_word;
    logic [CoalFactor*IdWidth-1:0] r_id;
    logic [TW-1:0]                 r_timer;

    logic [WIdx-1:0] w_widx;
    logic [TagW-1:0] w_tag;
    logic [BW-1:0]   w_lane_strb;
    logic            w_match;
    logic            w_unused;

    assign w_widx      = req_addr_i[LOff-1:2];
    assign w_tag       = req_addr_i[AddrWidth-1:LOff];
    assign w_unused    = ^req_addr_i[1:0];
    assign w_lane_strb = r_strb[w_widx*BW +: BW];
    // Writes may only merge into bytes of the lane not already claimed.
    assign w_match     = (w_tag == r_tag) && (req_write_i == r_write) &&
                         (!req_write_i || (req_strb_i & w_lane_strb) == '0);
    assign req_ready_o = (r_state == IDLE) || (r_state == COLLECT && req_valid_i && w_match);

    assign line_valid_o = (r_state == ISSUE);
    assign line_addr_o  = {r_tag, {LOff{1'b0}}};
    assign line_write_o = r_write;
    assign line_data_o  = r_data;
    assign line_strb_o  = r_strb;
    assign line_cnt_o   = r_cnt;
    assign line_word_o  = r_word;
    assign line_id_o    = r_id;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_tag   <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
            r_strb  <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_id    <= '0;
            r_timer <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid_i) begin
                    r_tag   <= w_tag;
                    r_write <= req_write_i;
                    r_data  <= '0;
                    r_data[w_widx*DataWidth +: DataWidth] <= req_data_i;
                    r_strb  <= '0;
                    r_strb[w_widx*BW +: BW] <= req_strb_i;
                    r_word  <= '0;
                    r_word[WIdx-1:0] <= w_widx;
                    r_id    <= '0;
                    r_id[IdWidth-1:0] <= req_id_i;
                    r_cnt   <= CW'(1);
                    r_timer <= '0;
                    r_state <= (CoalFactor == 1) ? ISSUE : COLLECT;
                end
                COLLECT: if (req_ready_o) begin
                    for (int b = 0; b < BW; b++)
                        if (req_strb_i[b])
                            r_data[w_widx*DataWidth + b*8 +: 8] <= req_data_i[b*8 +: 8];
                    r_strb[w_widx*BW +: BW] <= w_lane_strb | req_strb_i;
                    for (int k = 0; k < CoalFactor; k++)
                        if (CW'(k) == r_cnt) begin
                            r_word[k*WIdx +: WIdx]       <= w_widx;
                            r_id[k*IdWidth +: IdWidth]   <= req_id_i;
                        end
                    r_cnt   <= r_cnt + CW'(1);
                    r_timer <= '0;
                    if (r_cnt == CW'(CoalFactor - 1))
                        r_state <= ISSUE;
                end else begin
                    // Without an accept, a pending valid request is a mismatch.
                    r_timer <= r_timer + TW'(1);
                    if (req_valid_i || r_timer == TW'(TimeoutCycles - 1))
                        r_state <= ISSUE;
                end
                ISSUE: if (line_ready_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cachepool_l1_coalescer.sv
// tb_cachepool_l1_coalescer: cycle-by-cycle vector table plus hand-written backpressure and reset sequences.
module tb_cachepool_l1_coalescer;
    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [31:0]  req_addr_i;
    logic         req_write_i;
    logic [31:0]  req_data_i;
    logic [3:0]   req_strb_i;
    logic [5:0]   req_id_i;
    logic         line_valid_o;
    logic         line_ready_i;
    logic [31:0]  line_addr_o;
    logic         line_write_o;
    logic [127:0] line_data_o;
    logic [15:0]  line_strb_o;
    logic [1:0]   line_cnt_o;
    logic [3:0]   line_word_o;
    logic [11:0]  line_id_o;

    int n_pass = 0;
    int n_total = 0;

    cachepool_l1_coalescer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_write_i(req_write_i), .req_data_i(req_data_i), .req_strb_i(req_strb_i),
        .req_id_i(req_id_i), .line_valid_o(line_valid_o), .line_ready_i(line_ready_i),
        .line_addr_o(line_addr_o), .line_write_o(line_write_o), .line_data_o(line_data_o),
        .line_strb_o(line_strb_o), .line_cnt_o(line_cnt_o), .line_word_o(line_word_o),
        .line_id_o(line_id_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         v;
        logic [31:0]  a;
        logic         w;
        logic [31:0]  d;
        logic [3:0]   s;
        logic [5:0]   id;
        logic         lr;
        logic         e_rdy;
        logic         e_lv;
        logic         chk;
        logic [31:0]  e_addr;
        logic         e_w;
        logic [1:0]   e_cnt;
        logic [3:0]   e_word;
        logic [11:0]  e_id;
        logic [127:0] e_data;
        logic [15:0]  e_strb;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic v, logic [31:0] a, logic w, logic [31:0] d, logic [3:0] s,
                                logic [5:0] id, logic lr, logic er, logic el);
        vec_t t;
        t = '{default: '0};
        t.v = v; t.a = a; t.w = w; t.d = d; t.s = s; t.id = id; t.lr = lr;
        t.e_rdy = er; t.e_lv = el;
        tbl.push_back(t);
    endfunction

    function automatic void exp_line(logic [31:0] a, logic w, logic [1:0] c, logic [3:0] wd,
                                     logic [11:0] ids, logic [127:0] dt, logic [15:0] st);
        vec_t t;
        t = tbl.pop_back();
        t.chk = 1'b1; t.e_addr = a; t.e_w = w; t.e_cnt = c; t.e_word = wd;
        t.e_id = ids; t.e_data = dt; t.e_strb = st;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drv(input logic v, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic [5:0] id, input logic lr);
        @(posedge clk_i);
        #1;
        req_valid_i = v; req_addr_i = a; req_write_i = w; req_data_i = d;
        req_strb_i = s; req_id_i = id; line_ready_i = lr;
        @(negedge clk_i);
    endtask

    int hs;

    initial begin
        rst_ni = 1'b0;
        req_valid_i = 0; req_addr_i = 0; req_write_i = 0; req_data_i = 0;
        req_strb_i = 0; req_id_i = 0; line_ready_i = 0;

        // Merge two reads
        add(1, 32'h5180_0004, 0, 0, 0, 3, 1, 1, 0);
        add(1, 32'h5180_0008, 0, 0, 0, 5, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 1); exp_line(32'h5180_0000, 0, 2, 4'h9, 12'h143, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0);
        // Timeout flush
        add(1, 32'h5180_000C, 0, 0, 0, 7, 1, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 1); exp_line(32'h5180_0000, 0, 1, 4'h3, 12'h007, 0, 0);
        // Line mismatch, held request becomes the next window
        add(1, 32'h5180_0000, 0, 0, 0, 1, 1, 1, 0);
        add(1, 32'h5180_0010, 0, 0, 0, 2, 1, 0, 0);
        add(1, 32'h5180_0010, 0, 0, 0, 2, 1, 0, 1); exp_line(32'h5180_0000, 0, 1, 4'h0, 12'h001, 0, 0);
        add(1, 32'h5180_0010, 0, 0, 0, 2, 1, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 1); exp_line(32'h5180_0010, 0, 1, 4'h0, 12'h002, 0, 0);
        // Write strobes disjoint: merged
        add(1, 32'h8000_0000, 1, 32'h0000_BEEF, 4'h3, 4, 1, 1, 0);
        add(1, 32'h8000_0000, 1, 32'hCAFE_0000, 4'hC, 6, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 1);
        exp_line(32'h8000_0000, 1, 2, 4'h0, 12'h184, 128'hCAFE_BEEF, 16'h000F);
        // Write strobes overlapping: two requests in order
        add(1, 32'h8000_0000, 1, 32'h0000_BEEF, 4'h3, 4, 1, 1, 0);
        add(1, 32'h8000_0000, 1, 32'hCAFE_0000, 4'h3, 6, 1, 0, 0);
        add(1, 32'h8000_0000, 1, 32'hCAFE_0000, 4'h3, 6, 1, 0, 1);
        exp_line(32'h8000_0000, 1, 1, 4'h0, 12'h004, 128'h0000_BEEF, 16'h0003);
        add(1, 32'h8000_0000, 1, 32'hCAFE_0000, 4'h3, 6, 1, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 1);
        exp_line(32'h8000_0000, 1, 1, 4'h0, 12'h006, 128'hCAFE_0000, 16'h0003);

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset rdy", req_ready_o, 1);
        chk("reset lv", line_valid_o, 0);
        chk("reset addr", line_addr_o, 0);
        chk("reset data", line_data_o, 0);
        chk("reset id", line_id_o, 0);
        rst_ni = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].v, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].s, tbl[i].id, tbl[i].lr);
            chk($sformatf("v%0d rdy", i), req_ready_o, tbl[i].e_rdy);
            chk($sformatf("v%0d lv", i), line_valid_o, tbl[i].e_lv);
            if (tbl[i].chk) begin
                chk($sformatf("v%0d addr", i), line_addr_o, tbl[i].e_addr);
                chk($sformatf("v%0d write", i), line_write_o, tbl[i].e_w);
                chk($sformatf("v%0d cnt", i), line_cnt_o, tbl[i].e_cnt);
                chk($sformatf("v%0d word", i), line_word_o, tbl[i].e_word);
                chk($sformatf("v%0d id", i), line_id_o, tbl[i].e_id);
                chk($sformatf("v%0d data", i), line_data_o, tbl[i].e_data);
                chk($sformatf("v%0d strb", i), line_strb_o, tbl[i].e_strb);
            end
        end

        // Backpressure: payload must hold while line_ready_i is low
        drv(1, 32'h1000_0004, 0, 0, 0, 9, 0);
        chk("bp acc0 rdy", req_ready_o, 1);
        drv(1, 32'h1000_0000, 0, 0, 0, 10, 0);
        chk("bp acc1 rdy", req_ready_o, 1);
        for (int i = 0; i < 11; i++) begin
            drv(1, 32'h1000_0008, 0, 0, 0, 13, 0);
            chk($sformatf("bp%0d lv", i), line_valid_o, 1);
            chk($sformatf("bp%0d rdy", i), req_ready_o, 0);
            chk($sformatf("bp%0d addr", i), line_addr_o, 32'h1000_0000);
            chk($sformatf("bp%0d cnt", i), line_cnt_o, 2);
            chk($sformatf("bp%0d word", i), line_word_o, 4'h1);
            chk($sformatf("bp%0d id", i), line_id_o, 12'h289);
        end
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            drv(0, 0, 0, 0, 0, 0, 1);
            if (line_valid_o && line_ready_i) hs++;
        end
        chk("bp handshakes", hs, 1);

        // Asynchronous reset while a line request is pending
        drv(1, 32'h2000_0000, 0, 0, 0, 11, 0);
        drv(1, 32'h2000_0004, 0, 0, 0, 12, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("rst pre lv", line_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst async lv", line_valid_o, 0);
        chk("rst async rdy", req_ready_o, 1);
        chk("rst async addr", line_addr_o, 0);
        chk("rst async cnt", line_cnt_o, 0);
        chk("rst async word", line_word_o, 0);
        chk("rst async id", line_id_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            drv(0, 0, 0, 0, 0, 0, 1);
            if (line_valid_o) hs++;
        end
        chk("rst no stale", hs, 0);
        chk("rst post rdy", req_ready_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
